tb_checker: RTL and testbench

//  Testbench output checker; the counterpart of the bench clock/reset/end-of-sim controller.

---
 rtl/tb_checker_pkg.sv | 35 +++
 rtl/tb_checker_lfsr16.sv | 26 ++
 rtl/tb_checker.sv | 179 +++++++++++++++++
 tb/tb_tb_checker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_checker_pkg.sv
// Shared bench package for the output checker and its stimulus helpers.
//   chk_state_t  : checker sequencing states (IDLE/RUN/TAIL/DONE)
//   LFSR_SEED    : default seed of the 16-bit backpressure LFSR
//   LFSR_TAPS    : feedback mask for x^16+x^14+x^13+x^11 (right-shifting Fibonacci form)
//   lfsr16_next  : one LFSR step
//   bp_mask      : 16-entry table, bit n set when nibble value n must stall the stream
package tb_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_TAIL,
        ST_DONE
    } chk_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Shifting right, polynomial taps 16/14/13/11 land on state bits 0/2/3/5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] s, input logic [15:0] taps);
        return {^(s & taps), s[15:1]};
    endfunction

    // Table form of "nibble < thresh"; avoids a constant compare when thresh is 0.
    function automatic logic [15:0] bp_mask(input int thresh);
        logic [15:0] m;
        m = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (int'(i) < thresh) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/tb_checker_lfsr16.sv
// 16-bit Fibonacci LFSR, reusable by stimulus generators.
//   clk   : clock
//   rst   : synchronous active-high reset, loads SEED
//   en    : advance one step this cycle
//   state : current LFSR state
module tb_lfsr16
    import tb_checker_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED,
    parameter logic [15:0] TAPS = LFSR_TAPS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (en) begin
            state <= lfsr16_next(state, TAPS);
        end
    end

endmodule

// File: rtl/tb_checker.sv
// Testbench output checker. Accepts the DUT code stream over valid/ready, compares
// each word with an expected-vector memory and drives end-of-test controls.
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle pulse, latches exp_count/cmp_limit and starts a run
//   exp_count       : words the DUT must produce
//   cmp_limit       : 0 = compare all, else compare first cmp_limit words only
//   count_vec       : controller cycle count, captured at the first error
//   dout/dout_valid : DUT word and valid; dout_ready is the pseudo-random ready
//   exp_wr_*        : write port that loads the expected-vector memory
//   error           : sticky, any mismatch, surplus word or oversize request
//   do_stop         : stop-on-error end of test
//   do_finish       : normal end of test
//   partial_test    : run ended after cmp_limit < exp_count words
//   timeout         : constant TIMEOUT_CYCLES
//   err_count       : mismatch count, saturating
//   first_err_cycle : count_vec value at the first error
module tb_checker
    import tb_checker_pkg::*;
#(
    parameter int DATA_WIDTH     = 12,
    parameter int EXP_DEPTH      = 4096,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int BP_THRESH      = 4,
    parameter int TAIL_CYCLES    = 64,
    parameter int STOP_ON_ERROR  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [15:0]                  exp_count,
    input  logic [15:0]                  cmp_limit,
    input  logic [31:0]                  count_vec,
    input  logic [DATA_WIDTH-1:0]        dout,
    input  logic                         dout_valid,
    output logic                         dout_ready,
    input  logic                         exp_wr_en,
    input  logic [$clog2(EXP_DEPTH)-1:0] exp_wr_addr,
    input  logic [DATA_WIDTH-1:0]        exp_wr_data,
    output logic                         error,
    output logic                         do_stop,
    output logic                         do_finish,
    output logic                         partial_test,
    output logic [31:0]                  timeout,
    output logic [15:0]                  err_count,
    output logic [31:0]                  first_err_cycle
);

    localparam int          AW        = $clog2(EXP_DEPTH);
    localparam logic [16:0] DEPTH17   = 17'(EXP_DEPTH);
    localparam logic [15:0] TAIL_LAST = 16'(TAIL_CYCLES - 1);
    localparam logic [15:0] BP_MASK   = bp_mask(BP_THRESH);
    localparam bit          STOP_EN   = (STOP_ON_ERROR != 0);

    chk_state_t            state;
    logic [15:0]           idx;
    logic [15:0]           lim;
    logic                  partial_run;
    logic [15:0]           tail_cnt;
    logic [15:0]           lfsr;
    logic                  unused_lfsr_hi;
    logic [DATA_WIDTH-1:0] exp_mem [EXP_DEPTH];

    logic                  accept;
    logic                  mismatch;
    logic                  lim_partial;
    logic [15:0]           lim_next;

    assign timeout = 32'(TIMEOUT_CYCLES);

    tb_lfsr16 #(
        .SEED (LFSR_SEED),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (state == ST_RUN),
        .state (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:4];

    always_ff @(posedge clk) begin
        if (exp_wr_en) exp_mem[exp_wr_addr] <= exp_wr_data;
    end

    always_comb begin
        dout_ready = 1'b0;
        case (state)
            ST_RUN:  dout_ready = !BP_MASK[lfsr[3:0]];
            ST_TAIL: dout_ready = 1'b1;
            default: dout_ready = 1'b0;
        endcase
    end

    always_comb begin
        accept      = dout_valid & dout_ready;
        mismatch    = (dout != exp_mem[idx[AW-1:0]]);
        lim_partial = (cmp_limit != '0) && (cmp_limit < exp_count);
        lim_next    = lim_partial ? cmp_limit : exp_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            error           <= 1'b0;
            do_stop         <= 1'b0;
            do_finish       <= 1'b0;
            partial_test    <= 1'b0;
            err_count       <= '0;
            first_err_cycle <= '0;
            idx             <= '0;
            lim             <= '0;
            partial_run     <= 1'b0;
            tail_cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx         <= '0;
                        tail_cnt    <= '0;
                        lim         <= lim_next;
                        partial_run <= lim_partial;
                        if ({1'b0, exp_count} > DEPTH17) begin
                            error     <= 1'b1;
                            do_finish <= 1'b1;
                            if (!error) first_err_cycle <= count_vec;
                            state     <= ST_DONE;
                        end else if (exp_count == '0) begin
                            state <= ST_TAIL;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        idx <= idx + 16'd1;
                        if (mismatch) begin
                            error <= 1'b1;
                            if (err_count != '1) err_count <= err_count + 16'd1;
                            if (!error) first_err_cycle <= count_vec;
                        end
                        // Stop-on-error takes priority even when the bad word is the last one.
                        if (mismatch && STOP_EN) begin
                            do_stop <= 1'b1;
                            state   <= ST_DONE;
                        end else if (idx == lim - 16'd1) begin
                            if (partial_run) begin
                                partial_test <= 1'b1;
                                do_finish    <= 1'b1;
                                state        <= ST_DONE;
                            end else begin
                                state <= ST_TAIL;
                            end
                        end
                    end
                end
                ST_TAIL: begin
                    // Any word offered after the last expected one is a surplus word.
                    if (dout_valid) begin
                        error <= 1'b1;
                        if (!error) first_err_cycle <= count_vec;
                    end
                    if (tail_cnt == TAIL_LAST) begin
                        do_finish <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        tail_cnt <= tail_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tb_checker.sv
// Directed bench for tb_checker: three instances cover BP_THRESH=0 / STOP_ON_ERROR=0,
// BP_THRESH=0 / STOP_ON_ERROR=1 and BP_THRESH=8. Inputs change and outputs are
// sampled on the falling edge.
module tb_tb_checker;

    localparam int DW    = 12;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [15:0]   exp_count;
    logic [15:0]   cmp_limit;
    logic [31:0]   count_vec;
    logic          wr_en;
    logic [9:0]    wr_addr;
    logic [DW-1:0] wr_data;

    logic          start_v   [3];
    logic [DW-1:0] dout_v    [3];
    logic          valid_v   [3];
    logic          ready_v   [3];
    logic          error_v   [3];
    logic          stop_v    [3];
    logic          finish_v  [3];
    logic          partial_v [3];
    logic [31:0]   tmo_v     [3];
    logic [15:0]   errc_v    [3];
    logic [31:0]   ferr_v    [3];

    int            n_vec  = 0;
    int            n_miss = 0;
    int            lows;
    logic [2:0]    rdy_hist;
    logic [31:0]   bad_cycle;
    int            acc;
    int            nwait;

    tb_checker #(.DATA_WIDTH(DW), .EXP_DEPTH(DEPTH), .TIMEOUT_CYCLES(100000),
                 .BP_THRESH(0), .TAIL_CYCLES(64), .STOP_ON_ERROR(0)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .exp_count(exp_count),
        .cmp_limit(cmp_limit), .count_vec(count_vec), .dout(dout_v[0]),
        .dout_valid(valid_v[0]), .dout_ready(ready_v[0]), .exp_wr_en(wr_en),
        .exp_wr_addr(wr_addr), .exp_wr_data(wr_data), .error(error_v[0]),
        .do_stop(stop_v[0]), .do_finish(finish_v[0]), .partial_test(partial_v[0]),
        .timeout(tmo_v[0]), .err_count(errc_v[0]), .first_err_cycle(ferr_v[0]));

    tb_checker #(.DATA_WIDTH(DW), .EXP_DEPTH(DEPTH), .TIMEOUT_CYCLES(100000),
                 .BP_THRESH(0), .TAIL_CYCLES(64), .STOP_ON_ERROR(1)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .exp_count(exp_count),
        .cmp_limit(cmp_limit), .count_vec(count_vec), .dout(dout_v[1]),
        .dout_valid(valid_v[1]), .dout_ready(ready_v[1]), .exp_wr_en(wr_en),
        .exp_wr_addr(wr_addr), .exp_wr_data(wr_data), .error(error_v[1]),
        .do_stop(stop_v[1]), .do_finish(finish_v[1]), .partial_test(partial_v[1]),
        .timeout(tmo_v[1]), .err_count(errc_v[1]), .first_err_cycle(ferr_v[1]));

    tb_checker #(.DATA_WIDTH(DW), .EXP_DEPTH(DEPTH), .TIMEOUT_CYCLES(5000),
                 .BP_THRESH(8), .TAIL_CYCLES(64), .STOP_ON_ERROR(0)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .exp_count(exp_count),
        .cmp_limit(cmp_limit), .count_vec(count_vec), .dout(dout_v[2]),
        .dout_valid(valid_v[2]), .dout_ready(ready_v[2]), .exp_wr_en(wr_en),
        .exp_wr_addr(wr_addr), .exp_wr_data(wr_data), .error(error_v[2]),
        .do_stop(stop_v[2]), .do_finish(finish_v[2]), .partial_test(partial_v[2]),
        .timeout(tmo_v[2]), .err_count(errc_v[2]), .first_err_cycle(ferr_v[2]));

    // Free-running cycle count, settled well before each falling edge.
    initial begin
        count_vec = '0;
        forever begin
            @(posedge clk);
            #1 count_vec = count_vec + 32'd1;
        end
    end

    // Expected vector n; word 3 is 0x100.
    function automatic logic [DW-1:0] exp_word(input int n);
        logic [DW-1:0] v;
        v = DW'((n - 3) * 53);
        return v + 12'h100;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            valid_v[i] = 1'b0;
            dout_v[i]  = '0;
        end
        exp_count = '0;
        cmp_limit = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start(input int k, input logic [15:0] ec, input logic [15:0] cl);
        exp_count  = ec;
        cmp_limit  = cl;
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    // Offers words 0..n-1 in order; word 'bad' is corrupted by xor 0x1FF.
    task automatic send_stream(input int k, input int n, input int bad, input int budget,
                               output int accepted);
        int cyc;
        cyc      = 0;
        accepted = 0;
        lows     = 0;
        rdy_hist = '0;
        while (accepted < n && cyc < budget) begin
            valid_v[k] = 1'b1;
            dout_v[k]  = (accepted == bad) ? (exp_word(accepted) ^ 12'h1FF) : exp_word(accepted);
            if (cyc < 3) rdy_hist[cyc] = ready_v[k];
            if (ready_v[k]) begin
                if (accepted == bad) bad_cycle = count_vec;
                accepted++;
            end else begin
                lows++;
            end
            cyc++;
            @(negedge clk);
        end
        valid_v[k] = 1'b0;
    endtask

    task automatic wait_end(input int k, input int budget, output int n);
        n = 0;
        while (!finish_v[k] && !stop_v[k] && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        exp_count = '0;
        cmp_limit = '0;
        bad_cycle = '0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            valid_v[i] = 1'b0;
            dout_v[i]  = '0;
        end

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 10'(i);
            wr_data = exp_word(i);
        end
        @(negedge clk);
        wr_en = 1'b0;

        // Reset values
        do_reset();
        check_val("rst_ready",   32'(ready_v[0]),   0);
        check_val("rst_error",   32'(error_v[0]),   0);
        check_val("rst_stop",    32'(stop_v[0]),    0);
        check_val("rst_finish",  32'(finish_v[0]),  0);
        check_val("rst_partial", 32'(partial_v[0]), 0);
        check_val("rst_errc",    32'(errc_v[0]),    0);
        check_val("timeout_a",   tmo_v[0],          100000);
        check_val("timeout_c",   tmo_v[2],          5000);

        // 1: clean 8-word run, 64 tail cycles
        pulse_start(0, 16'd8, 16'd0);
        send_stream(0, 8, -1, 50, acc);
        check_val("t1_accepted", 32'(acc), 8);
        wait_end(0, 200, nwait);
        check_val("t1_tail_len", 32'(nwait),       64);
        check_val("t1_finish",   32'(finish_v[0]), 1);
        check_val("t1_error",    32'(error_v[0]),  0);
        check_val("t1_stop",     32'(stop_v[0]),   0);
        check_val("t1_ready",    32'(ready_v[0]),  0);
        pulse_start(0, 16'd8, 16'd0);
        check_val("t1_start_ign", {30'd0, finish_v[0], ready_v[0]}, 32'b10);

        // 2: word 3 corrupted, keep going
        do_reset();
        pulse_start(0, 16'd8, 16'd0);
        send_stream(0, 8, 3, 50, acc);
        check_val("t2_error", 32'(error_v[0]), 1);
        check_val("t2_errc",  32'(errc_v[0]),  1);
        check_val("t2_ferr",  ferr_v[0],       bad_cycle);
        wait_end(0, 200, nwait);
        check_val("t2_tail_len", 32'(nwait),       64);
        check_val("t2_finish",   32'(finish_v[0]), 1);
        check_val("t2_stop",     32'(stop_v[0]),   0);

        // 3: word 3 corrupted, stop on error
        do_reset();
        pulse_start(1, 16'd8, 16'd0);
        send_stream(1, 4, 3, 20, acc);
        check_val("t3_accepted", 32'(acc),         4);
        check_val("t3_stop",     32'(stop_v[1]),   1);
        check_val("t3_finish",   32'(finish_v[1]), 0);
        check_val("t3_error",    32'(error_v[1]),  1);
        check_val("t3_errc",     32'(errc_v[1]),   1);
        check_val("t3_ready",    32'(ready_v[1]),  0);

        // 4: cmp_limit 5 of 8
        do_reset();
        pulse_start(0, 16'd8, 16'd5);
        send_stream(0, 5, -1, 50, acc);
        check_val("t4_accepted", 32'(acc),          5);
        check_val("t4_partial",  32'(partial_v[0]), 1);
        check_val("t4_finish",   32'(finish_v[0]),  1);
        check_val("t4_error",    32'(error_v[0]),   0);

        // 5: surplus ninth word
        do_reset();
        pulse_start(0, 16'd8, 16'd0);
        send_stream(0, 9, -1, 50, acc);
        check_val("t5_accepted", 32'(acc),        9);
        check_val("t5_error",    32'(error_v[0]), 1);
        check_val("t5_errc",     32'(errc_v[0]),  0);
        wait_end(0, 200, nwait);
        check_val("t5_tail_rest", 32'(nwait),       63);
        check_val("t5_finish",    32'(finish_v[0]), 1);
        check_val("t5_partial",   32'(partial_v[0]), 0);

        // 6: backpressure, 1000 words; LFSR ACE1 -> 5670 -> AB38 gives ready 0,0,1
        do_reset();
        pulse_start(2, 16'd1000, 16'd0);
        send_stream(2, 1000, -1, 4000, acc);
        check_val("t6_accepted", 32'(acc),      1000);
        check_val("t6_rdy_head", 32'(rdy_hist), 32'b100);
        check_val("t6_low_share", 32'((lows * 100 / (1000 + lows)) >= 40 &&
                                      (lows * 100 / (1000 + lows)) <= 60), 1);
        wait_end(2, 200, nwait);
        check_val("t6_tail_len", 32'(nwait),       64);
        check_val("t6_finish",   32'(finish_v[2]), 1);
        check_val("t6_error",    32'(error_v[2]),  0);

        // 6b: reset mid-stream clears sticky flags and reseeds the LFSR
        do_reset();
        pulse_start(2, 16'd1000, 16'd0);
        send_stream(2, 100, 50, 600, acc);
        check_val("t6b_error_pre", 32'(error_v[2]), 1);
        check_val("t6b_errc_pre",  32'(errc_v[2]),  1);
        do_reset();
        check_val("t6b_ready",   32'(ready_v[2]),   0);
        check_val("t6b_error",   32'(error_v[2]),   0);
        check_val("t6b_errc",    32'(errc_v[2]),    0);
        check_val("t6b_ferr",    ferr_v[2],         0);
        check_val("t6b_finish",  32'(finish_v[2]),  0);
        check_val("t6b_partial", 32'(partial_v[2]), 0);
        pulse_start(2, 16'd8, 16'd0);
        send_stream(2, 3, -1, 50, acc);
        check_val("t6b_rdy_head", 32'(rdy_hist), 32'b100);

        // Boundaries: oversize request and empty run
        do_reset();
        pulse_start(0, 16'd1025, 16'd0);
        check_val("big_error",  32'(error_v[0]),  1);
        check_val("big_finish", 32'(finish_v[0]), 1);
        check_val("big_ready",  32'(ready_v[0]),  0);
        do_reset();
        pulse_start(0, 16'd0, 16'd0);
        check_val("zero_ready", 32'(ready_v[0]), 1);
        wait_end(0, 200, nwait);
        check_val("zero_tail_len", 32'(nwait),       64);
        check_val("zero_finish",   32'(finish_v[0]), 1);
        check_val("zero_error",    32'(error_v[0]),  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
